// File: rtl/reg_writeback.sv
// Register-file writeback arbiter: merges single-cycle ALU results with a FIFO of
// multi-cycle (load/mul/div) results, and tracks pending destination registers.
module reg_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [4:0]               mdu_addr,
    input  logic [DATA_W-1:0]        mdu_data,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_addr,
    input  logic [4:0]               q1_addr,
    input  logic [4:0]               q2_addr,
    output logic                     q1_pending,
    output logic                     q2_pending,
    output logic                     wb_we,
    output logic [4:0]               wb_addr,
    output logic [DATA_W-1:0]        wb_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [4:0]        addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [31:0]       pending;
    logic [31:0]       pend_set;
    logic [31:0]       pend_clr;

    logic full;
    logic alu_wr;
    logic push;
    logic pop;

    assign full      = (fifo_count == FULL_CNT);
    assign alu_ready = ~full;
    assign mdu_ready = ~full;

    // r0 results are accepted but dropped, so the FIFO may drain in that cycle
    assign alu_wr = alu_valid && alu_ready && (alu_addr != 5'd0);
    assign push   = mdu_valid && mdu_ready && (mdu_addr != 5'd0);
    assign pop    = !alu_wr && (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= mdu_addr;
            data_mem[wr_ptr] <= mdu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else if (alu_wr) begin
            wb_we   <= 1'b1;
            wb_addr <= alu_addr;
            wb_data <= alu_data;
        end else if (pop) begin
            wb_we   <= 1'b1;
            wb_addr <= addr_mem[rd_ptr];
            wb_data <= data_mem[rd_ptr];
        end else begin
            wb_we   <= 1'b0;
        end
    end

    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (issue_valid && issue_addr != 5'd0) pend_set[issue_addr] = 1'b1;
        if (wb_we) pend_clr[wb_addr] = 1'b1;
    end

    // Set wins over clear so a re-issue in the writeback cycle stays pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~pend_clr) | pend_set;
    end

    assign q1_pending = (q1_addr != 5'd0) && pending[q1_addr];
    assign q2_pending = (q2_addr != 5'd0) && pending[q2_addr];

endmodule

// File: tb/tb_reg_writeback.sv
// Randomized and directed bench for reg_writeback; a queue-based reference model
// predicts each register-file write, which a monitor checks when wb_we fires.
module tb_reg_writeback;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              alu_valid = 1'b0, mdu_valid = 1'b0, issue_valid = 1'b0;
    logic              alu_ready, mdu_ready;
    logic [4:0]        alu_addr = '0, mdu_addr = '0, issue_addr = '0;
    logic [DATA_W-1:0] alu_data = '0, mdu_data = '0;
    logic [4:0]        q1_addr = '0, q2_addr = '0;
    logic              q1_pending, q2_pending;
    logic              wb_we;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [$clog2(DEPTH):0] fifo_count;

    reg_writeback #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_pending(q1_pending), .q2_pending(q2_pending),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    // Reference model state
    logic [36:0] m_fifo[$];
    bit          m_pend[32];
    logic        m_we;
    logic [4:0]  m_addr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write the DUT presents must be the next one the model predicted
    always @(posedge clk) begin
        #1;
        if (wb_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wb", {27'd0, wb_addr}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
                chk("wb_data", wb_data, e.data);
                chk("wb_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic logic exp_pend(input logic [4:0] a);
        return (a != 5'd0) && m_pend[a];
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
        m_we = 1'b0;
        m_addr = '0;
    endtask

    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md,
                        input logic iv, input logic [4:0] ia, input logic [4:0] qa);
        logic       has_room, out_we;
        logic [4:0] out_a;
        logic [31:0] out_d;
        logic [36:0] ent;
        @(negedge clk);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mdu_valid = mv; mdu_addr = ma; mdu_data = md;
        issue_valid = iv; issue_addr = ia;
        q1_addr = qa; q2_addr = 5'($urandom_range(0, 31));
        #1;
        has_room = (m_fifo.size() < DEPTH);
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, has_room});
        chk("mdu_ready", {31'd0, mdu_ready}, {31'd0, has_room});
        chk("fifo_count", {29'd0, fifo_count}, m_fifo.size());
        chk("q1_pending", {31'd0, q1_pending}, {31'd0, exp_pend(q1_addr)});
        chk("q2_pending", {31'd0, q2_pending}, {31'd0, exp_pend(q2_addr)});
        out_we = 1'b0; out_a = '0; out_d = '0;
        if (av && has_room && aa != 5'd0) begin
            out_we = 1'b1; out_a = aa; out_d = ad;
        end else if (m_fifo.size() > 0) begin
            ent = m_fifo.pop_front();
            out_we = 1'b1; out_a = ent[36:32]; out_d = ent[31:0];
        end
        if (mv && has_room && ma != 5'd0) m_fifo.push_back({ma, md});
        if (m_we) m_pend[m_addr] = 0;
        if (iv && ia != 5'd0) m_pend[ia] = 1;
        if (out_we) begin
            exp_t e;
            e.addr = out_a; e.data = out_d; e.cyc = cyc + 1;
            exp_q.push_back(e);
            m_addr = out_a;
        end
        m_we = out_we;
        @(posedge clk);
    endtask

    task automatic idle(input int n, input logic [4:0] qa);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, qa);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_wb_we", {31'd0, wb_we}, 0);
        chk("rst_wb_addr", {27'd0, wb_addr}, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_fifo_count", {29'd0, fifo_count}, 0);
        chk("rst_alu_ready", {31'd0, alu_ready}, 1);
        chk("rst_mdu_ready", {31'd0, mdu_ready}, 1);
        rst = 1'b0;

        // Single ALU write to r5
        step(1, 5, 32'h0000_00AA, 0, 0, 0, 0, 0, 5);
        idle(2, 5);
        // Same-edge ALU r3 and MDU r4
        step(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 3);
        idle(3, 4);
        // ALU held busy while MDU fills the FIFO to full
        for (int i = 0; i < 4; i++) step(1, 5'(1 + i), 32'h100 + i, 1, 5'(10 + i), 32'h200 + i, 0, 0, 10);
        for (int i = 0; i < 4; i++) step(1, 5'(20 + i), 32'h300 + i, 0, 0, 0, 0, 0, 10);
        idle(6, 10);
        // Pending tracking for r7 including re-issue in the writeback cycle
        step(0, 0, 0, 0, 0, 0, 1, 7, 7);
        idle(2, 7);
        step(1, 7, 32'h77, 0, 0, 0, 0, 0, 7);
        step(0, 0, 0, 0, 0, 0, 1, 7, 7);
        idle(2, 7);
        step(1, 7, 32'h78, 0, 0, 0, 0, 0, 7);
        idle(2, 7);
        // r0 is never written and never pending
        step(1, 0, 32'hFFFF_FFFF, 1, 0, 32'hDEAD_BEEF, 1, 0, 0);
        idle(2, 0);

        // Reset mid-operation with three MDU entries queued
        step(0, 0, 0, 0, 0, 0, 1, 9, 9);
        for (int i = 0; i < 3; i++) step(1, 5'(1 + i), 32'h40 + i, 1, 5'(9 + i), 32'h50 + i, 0, 0, 9);
        @(negedge clk);
        rst = 1'b1;
        alu_valid = 0; mdu_valid = 0; issue_valid = 0;
        q1_addr = 9; q2_addr = 10;
        #1;
        chk("midrst_wb_we", {31'd0, wb_we}, 0);
        chk("midrst_fifo_count", {29'd0, fifo_count}, 0);
        chk("midrst_q1_pending", {31'd0, q1_pending}, 0);
        chk("midrst_q2_pending", {31'd0, q2_pending}, 0);
        chk("midrst_alu_ready", {31'd0, alu_ready}, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(4, 9);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                 1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), $urandom(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        idle(DEPTH + 4, 0);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
